// File: rtl/axilite_slave_regs.sv
// AXI4-Lite slave register bank.
// Holds C_NUM_REGS word-wide control registers, presents them flattened on
// regs_out, and emits a one-cycle wr_pulse for every register written.
// Write and read channels run independently; every AXI output is registered.
module axilite_slave_regs #(
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_AXI_ADDR_WIDTH = 8,
  parameter int C_NUM_REGS       = 8
) (
  input  logic                                 AXI_ACLK,
  input  logic                                 AXI_ARESETN,
  input  logic [C_AXI_ADDR_WIDTH-1:0]          AXI_AWADDR,
  input  logic [2:0]                           AXI_AWPROT,
  input  logic                                 AXI_AWVALID,
  output logic                                 AXI_AWREADY,
  input  logic [C_AXI_DATA_WIDTH-1:0]          AXI_WDATA,
  input  logic [C_AXI_DATA_WIDTH/8-1:0]        AXI_WSTRB,
  input  logic                                 AXI_WVALID,
  output logic                                 AXI_WREADY,
  output logic [1:0]                           AXI_BRESP,
  output logic                                 AXI_BVALID,
  input  logic                                 AXI_BREADY,
  input  logic [C_AXI_ADDR_WIDTH-1:0]          AXI_ARADDR,
  input  logic [2:0]                           AXI_ARPROT,
  input  logic                                 AXI_ARVALID,
  output logic                                 AXI_ARREADY,
  output logic [C_AXI_DATA_WIDTH-1:0]          AXI_RDATA,
  output logic [1:0]                           AXI_RRESP,
  output logic                                 AXI_RVALID,
  input  logic                                 AXI_RREADY,
  output logic [C_NUM_REGS*C_AXI_DATA_WIDTH-1:0] regs_out,
  output logic [C_NUM_REGS-1:0]                wr_pulse
);

  localparam int DW   = C_AXI_DATA_WIDTH;
  localparam int AW   = C_AXI_ADDR_WIDTH;
  localparam int NB   = DW / 8;
  localparam int IDXW = AW - 2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_ADDR = 2'd1,
    W_DATA = 2'd2,
    W_RESP = 2'd3
  } wstate_e;

  // Merge new data into an old word, byte lane by byte lane.
  function automatic logic [DW-1:0] apply_strb(input logic [DW-1:0] old_v,
                                               input logic [DW-1:0] new_v,
                                               input logic [NB-1:0] strb);
    logic [DW-1:0] res;
    res = old_v;
    for (int b = 0; b < NB; b++) begin
      if (strb[b]) begin
        res[b*8 +: 8] = new_v[b*8 +: 8];
      end else begin
        res[b*8 +: 8] = old_v[b*8 +: 8];
      end
    end
    return res;
  endfunction

  // A word index addresses a real register only below C_NUM_REGS.
  function automatic logic in_range(input logic [IDXW-1:0] idx);
    return (32'(idx) < 32'(C_NUM_REGS));
  endfunction

  // Write channel state
  wstate_e           wstate_q;
  logic              awready_q;
  logic              wready_q;
  logic              bvalid_q;
  logic [1:0]        bresp_q;
  logic [IDXW-1:0]   awidx_q;
  logic [DW-1:0]     wdata_q;
  logic [NB-1:0]     wstrb_q;

  // Read channel state
  logic              arready_q;
  logic              rvalid_q;
  logic [DW-1:0]     rdata_q;
  logic [1:0]        rresp_q;

  // Register bank
  logic [DW-1:0]         regs_q [C_NUM_REGS];
  logic [C_NUM_REGS-1:0] wr_pulse_q;

  // Decode and handshake helpers
  logic [IDXW-1:0] aw_idx_s;
  logic [IDXW-1:0] ar_idx_s;
  logic            aw_hs_s;
  logic            w_hs_s;
  logic            b_hs_s;
  logic            ar_hs_s;
  logic            r_hs_s;

  // Write commit selection
  logic            commit_s;
  logic            commit_ok_s;
  logic [IDXW-1:0] cidx_s;
  logic [DW-1:0]   cdata_s;
  logic [NB-1:0]   cstrb_s;
  logic [1:0]      cresp_s;

  logic [DW-1:0]   rd_word_s;
  logic            unused_s;

  assign aw_idx_s = AXI_AWADDR[AW-1:2];
  assign ar_idx_s = AXI_ARADDR[AW-1:2];
  assign aw_hs_s  = AXI_AWVALID & awready_q;
  assign w_hs_s   = AXI_WVALID & wready_q;
  assign b_hs_s   = bvalid_q & AXI_BREADY;
  assign ar_hs_s  = AXI_ARVALID & arready_q;
  assign r_hs_s   = rvalid_q & AXI_RREADY;

  // Protection bits and byte offsets carry no meaning for this bank.
  assign unused_s = ^{AXI_AWPROT, AXI_ARPROT, AXI_AWADDR[1:0], AXI_ARADDR[1:0]};

  // Pick the address/data pair that completes a write this cycle, taking
  // whichever half was latched earlier from the holding registers.
  always_comb begin
    commit_s = 1'b0;
    cidx_s   = aw_idx_s;
    cdata_s  = AXI_WDATA;
    cstrb_s  = AXI_WSTRB;
    case (wstate_q)
      W_IDLE: begin
        commit_s = aw_hs_s & w_hs_s;
      end
      W_ADDR: begin
        commit_s = w_hs_s;
        cidx_s   = awidx_q;
      end
      W_DATA: begin
        commit_s = aw_hs_s;
        cdata_s  = wdata_q;
        cstrb_s  = wstrb_q;
      end
      default: begin
        commit_s = 1'b0;
      end
    endcase
    commit_ok_s = commit_s & in_range(cidx_s);
    if (in_range(cidx_s)) begin
      cresp_s = RESP_OKAY;
    end else begin
      cresp_s = RESP_SLVERR;
    end
  end

  // Write FSM: collects AW and W in any order, then holds B until accepted.
  always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
    if (!AXI_ARESETN) begin
      wstate_q  <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      awidx_q   <= {IDXW{1'b0}};
      wdata_q   <= {DW{1'b0}};
      wstrb_q   <= {NB{1'b0}};
    end else if (commit_s) begin
      wstate_q  <= W_RESP;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b1;
      bresp_q   <= cresp_s;
    end else begin
      case (wstate_q)
        W_IDLE: begin
          if (aw_hs_s) begin
            wstate_q  <= W_ADDR;
            awidx_q   <= aw_idx_s;
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
          end else if (w_hs_s) begin
            wstate_q  <= W_DATA;
            wdata_q   <= AXI_WDATA;
            wstrb_q   <= AXI_WSTRB;
            awready_q <= 1'b1;
            wready_q  <= 1'b0;
          end else begin
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
          end
        end
        W_ADDR: begin
          awready_q <= 1'b0;
          wready_q  <= 1'b1;
        end
        W_DATA: begin
          awready_q <= 1'b1;
          wready_q  <= 1'b0;
        end
        W_RESP: begin
          if (b_hs_s) begin
            wstate_q  <= W_IDLE;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
          end else begin
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
          end
        end
        default: begin
          wstate_q  <= W_IDLE;
          awready_q <= 1'b0;
          wready_q  <= 1'b0;
          bvalid_q  <= 1'b0;
        end
      endcase
    end
  end

  // Register bank update and one-cycle write strobe on the commit edge.
  always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
    if (!AXI_ARESETN) begin
      wr_pulse_q <= {C_NUM_REGS{1'b0}};
      for (int i = 0; i < C_NUM_REGS; i++) begin
        regs_q[i] <= {DW{1'b0}};
      end
    end else begin
      for (int i = 0; i < C_NUM_REGS; i++) begin
        wr_pulse_q[i] <= commit_ok_s && (32'(cidx_s) == i);
        if (commit_ok_s && (32'(cidx_s) == i)) begin
          regs_q[i] <= apply_strb(regs_q[i], cdata_s, cstrb_s);
        end
      end
    end
  end

  // Read mux; an out-of-range index selects nothing and yields zero.
  always_comb begin
    rd_word_s = {DW{1'b0}};
    for (int i = 0; i < C_NUM_REGS; i++) begin
      rd_word_s = rd_word_s | ({DW{(32'(ar_idx_s) == i)}} & regs_q[i]);
    end
  end

  // Read channel: capture on AR handshake, hold R until accepted.
  always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
    if (!AXI_ARESETN) begin
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= {DW{1'b0}};
      rresp_q   <= 2'b00;
    end else if (ar_hs_s) begin
      arready_q <= 1'b0;
      rvalid_q  <= 1'b1;
      rdata_q   <= rd_word_s;
      if (in_range(ar_idx_s)) begin
        rresp_q <= RESP_OKAY;
      end else begin
        rresp_q <= RESP_SLVERR;
      end
    end else if (r_hs_s) begin
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
    end else begin
      arready_q <= ~rvalid_q;
    end
  end

  // Flatten the register array onto regs_out.
  for (genvar g = 0; g < C_NUM_REGS; g++) begin : g_regs_out
    assign regs_out[g*DW +: DW] = regs_q[g];
  end

  assign AXI_AWREADY = awready_q;
  assign AXI_WREADY  = wready_q;
  assign AXI_BVALID  = bvalid_q;
  assign AXI_BRESP   = bresp_q;
  assign AXI_ARREADY = arready_q;
  assign AXI_RVALID  = rvalid_q;
  assign AXI_RDATA   = rdata_q;
  assign AXI_RRESP   = rresp_q;
  assign wr_pulse    = wr_pulse_q;

endmodule
